// File: rtl/req_scheduler.sv
// req_scheduler: divides clk into periodic one-cycle sample requests and tracks unanswered requests.
// Optional underrun tracking is enabled with `define REQ_SCHEDULER_UNDERRUN_EN.
module req_scheduler #(
  parameter int RATE0_DIV = 2083,
  parameter int RATE1_DIV = 1042,
  parameter int RATE2_DIV = 521,
  parameter int RATE3_DIV = 260
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play_in,
  input  logic        cfg_in,
  input  logic [31:0] cfg_reg_in,
  input  logic        clr_in,
  input  logic        tick_in,
  output logic        req_out,
  output logic        busy_out,
  output logic        underrun_out,
  output logic [7:0]  underrun_cnt_out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q;
  logic [11:0] cnt_q, div_q, div_d, sel_div;
  logic        req_q, issue, unused_ok;
  always_comb begin
    sel_div = cfg_reg_in[1:0] == 2'd0 ? 12'(RATE0_DIV) :
              cfg_reg_in[1:0] == 2'd1 ? 12'(RATE1_DIV) :
              cfg_reg_in[1:0] == 2'd2 ? 12'(RATE2_DIV) : 12'(RATE3_DIV);
    div_d   = (state_q == IDLE && cfg_in) ? sel_div : div_q;
    issue   = state_q == RUN && play_in && cnt_q == 12'd0;
  end
  // div_d feeds the initial load so a cfg coinciding with play takes effect at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 12'(RATE0_DIV);
      req_q   <= 1'b0;
    end else begin
      div_q <= div_d;
      req_q <= issue;
      if (state_q == IDLE) begin
        if (play_in) begin
          state_q <= RUN;
          cnt_q   <= div_d - 12'd1;
        end
      end else if (!play_in) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= issue ? div_q - 12'd1 : cnt_q - 12'd1;
      end
    end
  end
  assign req_out  = req_q;
  assign busy_out = rst_n && state_q == RUN;
`ifdef REQ_SCHEDULER_UNDERRUN_EN
  logic       out_q, und_q, und_ev;
  logic [7:0] und_cnt_q;
  assign und_ev = issue & out_q & ~tick_in;
  // a tick on an issuing edge clears the old request but the new one re-arms outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= 1'b0;
      und_q     <= 1'b0;
      und_cnt_q <= '0;
    end else begin
      out_q     <= (state_q == RUN && !play_in) ? 1'b0 : issue | (out_q & ~tick_in);
      und_q     <= !clr_in && (und_q || und_ev);
      und_cnt_q <= clr_in ? 8'd0 : (und_ev && und_cnt_q != 8'hFF) ? und_cnt_q + 8'd1 : und_cnt_q;
    end
  end
  assign underrun_out     = und_q;
  assign underrun_cnt_out = und_cnt_q;
  assign unused_ok        = ^cfg_reg_in[31:2];
`else
  assign underrun_out     = 1'b0;
  assign underrun_cnt_out = 8'd0;
  assign unused_ok        = ^{cfg_reg_in[31:2], tick_in, clr_in};
`endif
endmodule

// File: doc/req_scheduler.md
REQ_SCHEDULER -- requirements
Module: req_scheduler

Interface
REQ-001 Parameter RATE0_DIV, default 2083, SHALL give the clock cycles per sample request for rate select 0.
REQ-002 Parameter RATE1_DIV, default 1042, SHALL give the cycles per request for rate select 1.
REQ-003 Parameter RATE2_DIV, default 521, SHALL give the cycles per request for rate select 2.
REQ-004 Parameter RATE3_DIV, default 260, SHALL give the cycles per request for rate select 3.
REQ-005 All RATEn_DIV values SHALL lie in 2..4095, and the divider SHALL be 12 bits wide.
REQ-006 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  SHALL be a synchronous, active-low reset.
REQ-008 play_in  in  1  SHALL be the play level from the control unit.
REQ-009 cfg_in  in  1  SHALL be a one-cycle configuration command strobe.
REQ-010 cfg_reg_in  in  32  SHALL be the configuration register; bits [1:0] select the rate and the other bits are ignored.
REQ-011 clr_in  in  1  SHALL be a one-cycle clear strobe.
REQ-012 tick_in  in  1  SHALL be the one-cycle acknowledgement that the datapath consumed a sample.
REQ-013 req_out  out  1  SHALL be a registered one-cycle sample request pulse.
REQ-014 busy_out  out  1  SHALL be 1 exactly when the state is RUN.
REQ-015 underrun_out  out  1  SHALL be the sticky underrun flag.
REQ-016 underrun_cnt_out  out  8  SHALL be the saturating underrun count.

Function
REQ-017 The FSM SHALL have two states: IDLE and RUN.
REQ-018 In IDLE with play_in=1, the next edge SHALL enter RUN and load cnt=div_r-1.
REQ-019 In RUN, each edge with cnt==0 SHALL set req_out=1 and reload cnt=div_r-1; otherwise cnt SHALL decrement and req_out SHALL be 0.
REQ-020 The first req_out SHALL appear div_r edges after the RUN-entry edge, and req_out SHALL then recur exactly every div_r cycles.
REQ-021 In RUN with play_in=0, the next edge SHALL enter IDLE and clear cnt, req_out and outstanding; no request SHALL be issued on that edge.
REQ-022 cfg_in in IDLE SHALL latch div_r from RATE[cfg_reg_in[1:0]]_DIV on the next edge.
REQ-023 cfg_in in RUN SHALL be ignored, so div_r never changes mid-play.
REQ-024 If cfg_in and play_in=1 coincide in IDLE, the new divider SHALL be latched and used for the initial cnt load.
REQ-025 The outstanding flag SHALL be set by every issued request and cleared by tick_in.
REQ-026 If tick_in coincides with an issuing edge, the clear and the set SHALL both apply, leaving outstanding=1.
REQ-027 tick_in while outstanding=0 SHALL be ignored.
REQ-028 An underrun event SHALL be an issuing edge with outstanding=1 and tick_in=0; the request SHALL still be issued.
REQ-029 An underrun event SHALL set underrun_out=1 and increment underrun_cnt_out, saturating at 255.
REQ-030 clr_in SHALL clear underrun_out and underrun_cnt_out, and SHALL take priority over a coincident underrun event.
REQ-031 clr_in SHALL NOT affect the FSM, cnt or outstanding.
REQ-032 Leaving RUN SHALL preserve underrun_out and underrun_cnt_out.

Reset
REQ-033 On an edge with rst_n=0, the block SHALL set state=IDLE, cnt=0, div_r=RATE0_DIV, req_out=0, outstanding=0, underrun_out=0 and underrun_cnt_out=0.
REQ-034 busy_out SHALL read 0 throughout reset.
REQ-035 A reset during RUN SHALL abort immediately, issuing no request on that edge.
REQ-036 With rst_n=0, all other inputs SHALL be ignored.

Configuration
REQ-037 With macro REQ_SCHEDULER_UNDERRUN_EN defined, the outstanding tracking and underrun logic SHALL be implemented as specified in REQ-025 to REQ-032.
REQ-038 With REQ_SCHEDULER_UNDERRUN_EN undefined, underrun_out and underrun_cnt_out SHALL be constant 0, tick_in and clr_in SHALL be ignored, and request timing SHALL be unchanged.

Verification
REQ-039 Bench SHALL cover: reset, then play_in=1 with default div 2083 -> first req_out 2083 edges after RUN entry, then every 2083 cycles, each 1 cycle wide.
REQ-040 Bench SHALL cover: in IDLE, cfg_in with cfg_reg_in[1:0]=3 -> after play, req_out period 260; cfg_in with [1:0]=1 during RUN -> period stays 260.
REQ-041 Bench SHALL cover: tick_in answers each req within 5 cycles -> underrun_out stays 0 over 10 requests.
REQ-042 Bench SHALL cover: no tick_in for 300 consecutive requests (macro defined) -> underrun_out=1 from the 2nd request, underrun_cnt_out saturates at 255; then clr_in -> both 0 on the next edge.
REQ-043 Bench SHALL cover: play_in dropped when cnt==0 is due -> no req_out, busy_out=0 next cycle; a replay restarts the full div_r period.
REQ-044 Bench SHALL cover: rst_n=0 for one edge mid-RUN -> all outputs 0 and div_r=RATE0_DIV on the next cycle.
